// File: rtl/key_table_if.sv
// Request/response bundle for key_table: insert, delete and lookup ports
// plus the registered table view that feeds the downstream index mux.
interface key_table_if #(
  parameter int NR = 4,
  parameter int KW = 8,
  parameter int IW = 3
);
  logic             ins_valid;
  logic             ins_ready;
  logic [KW-1:0]    ins_key;
  logic             ins_done;
  logic [IW-1:0]    ins_idx;
  logic             ins_dup;
  logic             del_valid;
  logic [IW-1:0]    del_idx;
  logic             look_valid;
  logic [KW-1:0]    look_key;
  logic             hit_valid;
  logic [IW-1:0]    hit_idx;
  logic [NR*KW-1:0] keys;
  logic [NR-1:0]    valid_mask;
  logic [IW-1:0]    count;
  logic             full;
  logic             empty;

  modport slave (
    input  ins_valid, ins_key, del_valid, del_idx, look_valid, look_key,
    output ins_ready, ins_done, ins_idx, ins_dup, hit_valid, hit_idx,
           keys, valid_mask, count, full, empty
  );

  modport master (
    output ins_valid, ins_key, del_valid, del_idx, look_valid, look_key,
    input  ins_ready, ins_done, ins_idx, ins_dup, hit_valid, hit_idx,
           keys, valid_mask, count, full, empty
  );
endinterface

// File: rtl/key_table.sv
// NR-entry registered key table: lowest-free-slot insert with duplicate
// detection, delete by 1-based index, registered lowest-index lookup.
module key_slot #(
  parameter int KW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr,
  input  logic          clr,
  input  logic [KW-1:0] ins_key,
  input  logic [KW-1:0] look_key,
  output logic          vld,
  output logic [KW-1:0] key,
  output logic          ins_hit,
  output logic          look_hit
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld <= 1'b0;
      key <= '0;
    end else if (clr) begin
      vld <= 1'b0;
      key <= '0;
    end else if (wr) begin
      vld <= 1'b1;
      key <= ins_key;
    end
  end

  // freed slots hold key 0, so the valid qualifier is what stops a 0 match
  assign ins_hit  = vld && (key == ins_key);
  assign look_hit = vld && (key == look_key);
endmodule

module key_table #(
  parameter int NR = 4,
  parameter int KW = 8,
  parameter int IW = 3
) (
  input logic        clk,
  input logic        rst,
  key_table_if.slave bus
);
  localparam logic [IW-1:0] NR_I = IW'(NR);

  logic [NR-1:0]          vld, ins_hit, look_hit, del_sel, del_eff, free_oh, alloc_sel;
  logic [NR-1:0][KW-1:0]  key;
  logic [IW-1:0]          cnt;
  logic                   full_w, ins_fire, dup_w, alloc;
  logic                   ins_done_q, ins_dup_q, hit_valid_q;
  logic [IW-1:0]          ins_idx_q, hit_idx_q;

  function automatic logic [IW-1:0] lowest(input logic [NR-1:0] v);
    lowest = '0;
    for (int i = NR - 1; i >= 0; i--)
      if (v[i]) lowest = IW'(i + 1);
  endfunction

  genvar g;
  generate
    for (g = 0; g < NR; g++) begin : g_slot
      assign del_sel[g] = bus.del_valid && (bus.del_idx == IW'(g + 1));
      key_slot #(.KW(KW)) u_slot (
        .clk      (clk),
        .rst      (rst),
        .wr       (alloc_sel[g]),
        .clr      (del_eff[g]),
        .ins_key  (bus.ins_key),
        .look_key (bus.look_key),
        .vld      (vld[g]),
        .key      (key[g]),
        .ins_hit  (ins_hit[g]),
        .look_hit (look_hit[g])
      );
    end
  endgenerate

  // everything below keys off pre-cycle vld, so a slot freed this cycle is
  // never picked by a same-cycle insert and alloc/delete never collide
  assign full_w    = (cnt == NR_I);
  assign ins_fire  = bus.ins_valid && !full_w;
  assign dup_w     = |ins_hit;
  assign alloc     = ins_fire && !dup_w;
  assign free_oh   = ~vld & (vld + NR'(1));
  assign alloc_sel = alloc ? free_oh : '0;
  assign del_eff   = del_sel & vld;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      ins_done_q  <= 1'b0;
      ins_idx_q   <= '0;
      ins_dup_q   <= 1'b0;
      hit_valid_q <= 1'b0;
      hit_idx_q   <= '0;
    end else begin
      cnt        <= cnt + IW'(alloc) - IW'(|del_eff);
      ins_done_q <= ins_fire;
      if (ins_fire) begin
        ins_idx_q <= dup_w ? lowest(ins_hit) : lowest(~vld);
        ins_dup_q <= dup_w;
      end
      hit_valid_q <= bus.look_valid;
      if (bus.look_valid) hit_idx_q <= lowest(look_hit);
    end
  end

  assign bus.ins_ready  = !full_w;
  assign bus.ins_done   = ins_done_q;
  assign bus.ins_idx    = ins_idx_q;
  assign bus.ins_dup    = ins_dup_q;
  assign bus.hit_valid  = hit_valid_q;
  assign bus.hit_idx    = hit_idx_q;
  assign bus.keys       = key;
  assign bus.valid_mask = vld;
  assign bus.count      = cnt;
  assign bus.full       = full_w;
  assign bus.empty      = (cnt == '0);
endmodule

// File: tb/tb_key_table.sv
// Bench for key_table: directed vector table, reset corner cases and a
// randomized run against an array-based model of the table rules.
module tb_key_table;
  localparam int NR = 4;
  localparam int KW = 8;
  localparam int IW = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  key_table_if #(.NR(NR), .KW(KW), .IW(IW)) bus ();
  key_table #(.NR(NR), .KW(KW), .IW(IW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_chk = 0;
  int n_fail = 0;

  // model state
  bit            m_vld [NR];
  logic [KW-1:0] m_key [NR];
  bit            e_done, e_dup, e_hv;
  int            e_idx, e_hidx;

  typedef struct {
    bit iv; logic [KW-1:0] ik;
    bit dv; logic [IW-1:0] di;
    bit lv; logic [KW-1:0] lk;
    bit x_done; int x_idx; bit x_dup;
    bit x_hv;   int x_hidx;
    int x_cnt;  logic [NR-1:0] x_mask;
  } vec_t;
  vec_t tv[$];

  function automatic void chk(string name, longint unsigned act, longint unsigned exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h @%0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NR; i++) begin m_vld[i] = 0; m_key[i] = '0; end
    e_done = 0; e_dup = 0; e_hv = 0; e_idx = 0; e_hidx = 0;
  endfunction

  function automatic int find(logic [KW-1:0] k);
    for (int i = 0; i < NR; i++) if (m_vld[i] && m_key[i] == k) return i;
    return -1;
  endfunction

  function automatic void model_step(bit iv, logic [KW-1:0] ik, bit dv, logic [IW-1:0] di,
                                     bit lv, logic [KW-1:0] lk);
    int c = 0;
    int slot = -1;
    int j;
    for (int i = 0; i < NR; i++) c += int'(m_vld[i]);
    e_done = iv && (c < NR);
    if (e_done) begin
      j = find(ik);
      if (j >= 0) begin e_idx = j + 1; e_dup = 1; end
      else begin
        for (int i = NR - 1; i >= 0; i--) if (!m_vld[i]) slot = i;
        e_idx = slot + 1; e_dup = 0;
      end
    end
    e_hv = lv;
    if (lv) begin j = find(lk); e_hidx = j + 1; end
    if (dv && di >= 1 && int'(di) <= NR && m_vld[int'(di) - 1]) begin
      m_vld[int'(di) - 1] = 0; m_key[int'(di) - 1] = '0;
    end
    if (slot >= 0) begin m_vld[slot] = 1; m_key[slot] = ik; end
  endfunction

  task automatic compare_all();
    int c = 0;
    logic [NR-1:0] mk;
    logic [NR*KW-1:0] kk;
    for (int i = 0; i < NR; i++) begin
      c += int'(m_vld[i]); mk[i] = m_vld[i]; kk[KW*i +: KW] = m_key[i];
    end
    chk("ins_done",   bus.ins_done,   e_done);
    chk("ins_idx",    bus.ins_idx,    e_idx);
    chk("ins_dup",    bus.ins_dup,    e_dup);
    chk("hit_valid",  bus.hit_valid,  e_hv);
    chk("hit_idx",    bus.hit_idx,    e_hidx);
    chk("valid_mask", bus.valid_mask, mk);
    chk("keys",       bus.keys,       kk);
    chk("count",      bus.count,      c);
    chk("full",       bus.full,       c == NR);
    chk("empty",      bus.empty,      c == 0);
    chk("ins_ready",  bus.ins_ready,  c < NR);
  endtask

  task automatic cyc(bit iv, logic [KW-1:0] ik, bit dv, logic [IW-1:0] di,
                     bit lv, logic [KW-1:0] lk);
    @(negedge clk);
    bus.ins_valid = iv; bus.ins_key = ik;
    bus.del_valid = dv; bus.del_idx = di;
    bus.look_valid = lv; bus.look_key = lk;
    model_step(iv, ik, dv, di, lv, lk);
    @(posedge clk); #1;
    compare_all();
  endtask

  task automatic chk_reset_vals(string tag);
    chk({tag, "_mask"},  bus.valid_mask, 0);
    chk({tag, "_keys"},  bus.keys, 0);
    chk({tag, "_count"}, bus.count, 0);
    chk({tag, "_empty"}, bus.empty, 1);
    chk({tag, "_full"},  bus.full, 0);
    chk({tag, "_ready"}, bus.ins_ready, 1);
    chk({tag, "_done"},  bus.ins_done, 0);
    chk({tag, "_idx"},   bus.ins_idx, 0);
    chk({tag, "_dup"},   bus.ins_dup, 0);
    chk({tag, "_hv"},    bus.hit_valid, 0);
    chk({tag, "_hidx"},  bus.hit_idx, 0);
  endtask

  function automatic void add(bit iv, int ik, bit dv, int di, bit lv, int lk,
                              bit xd, int xi, bit xu, bit xh, int xhi, int xc, int xm);
    vec_t v;
    v.iv = iv; v.ik = KW'(ik); v.dv = dv; v.di = IW'(di); v.lv = lv; v.lk = KW'(lk);
    v.x_done = xd; v.x_idx = xi; v.x_dup = xu; v.x_hv = xh; v.x_hidx = xhi;
    v.x_cnt = xc; v.x_mask = NR'(xm);
    tv.push_back(v);
  endfunction

  initial begin
    rst = 1'b1;
    bus.ins_valid = 0; bus.ins_key = '0; bus.del_valid = 0; bus.del_idx = '0;
    bus.look_valid = 0; bus.look_key = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 chk_reset_vals("rst0");
    @(negedge clk) rst = 1'b0;

    //  iv ik     dv di  lv lk     done idx dup hv hidx cnt mask
    add(1, 'h11, 0, 0, 0, 0,     1, 1, 0, 0, 0, 1, 'b0001);
    add(1, 'h22, 0, 0, 0, 0,     1, 2, 0, 0, 0, 2, 'b0011);
    add(1, 'h33, 0, 0, 0, 0,     1, 3, 0, 0, 0, 3, 'b0111);
    add(1, 'h22, 0, 0, 0, 0,     1, 2, 1, 0, 0, 3, 'b0111);
    add(1, 'h55, 0, 0, 0, 0,     1, 4, 0, 0, 0, 4, 'b1111);
    add(1, 'h66, 0, 0, 0, 0,     0, 4, 0, 0, 0, 4, 'b1111);
    add(1, 'h66, 1, 2, 0, 0,     0, 4, 0, 0, 0, 3, 'b1101);
    add(1, 'h44, 0, 0, 0, 0,     1, 2, 0, 0, 0, 4, 'b1111);
    add(0, 0,    0, 0, 1, 'h33,  0, 2, 0, 1, 3, 4, 'b1111);
    add(0, 0,    0, 0, 1, 'h99,  0, 2, 0, 1, 0, 4, 'b1111);
    add(0, 0,    1, 3, 1, 'h33,  0, 2, 0, 1, 3, 3, 'b1011);
    add(0, 0,    0, 0, 1, 'h33,  0, 2, 0, 1, 0, 3, 'b1011);
    add(0, 0,    1, 0, 0, 0,     0, 2, 0, 0, 0, 3, 'b1011);
    add(0, 0,    1, 5, 0, 0,     0, 2, 0, 0, 0, 3, 'b1011);
    add(0, 0,    1, 3, 0, 0,     0, 2, 0, 0, 0, 3, 'b1011);
    add(0, 0,    1, 1, 0, 0,     0, 2, 0, 0, 0, 2, 'b1010);
    add(0, 0,    1, 2, 0, 0,     0, 2, 0, 0, 0, 1, 'b1000);
    add(0, 0,    1, 4, 0, 0,     0, 2, 0, 0, 0, 0, 'b0000);
    add(0, 0,    0, 0, 1, 'h00,  0, 2, 0, 1, 0, 0, 'b0000);

    for (int n = 0; n < tv.size(); n++) begin
      cyc(tv[n].iv, tv[n].ik, tv[n].dv, tv[n].di, tv[n].lv, tv[n].lk);
      chk($sformatf("v%0d_done", n), bus.ins_done,   tv[n].x_done);
      chk($sformatf("v%0d_idx", n),  bus.ins_idx,    tv[n].x_idx);
      chk($sformatf("v%0d_dup", n),  bus.ins_dup,    tv[n].x_dup);
      chk($sformatf("v%0d_hv", n),   bus.hit_valid,  tv[n].x_hv);
      chk($sformatf("v%0d_hidx", n), bus.hit_idx,    tv[n].x_hidx);
      chk($sformatf("v%0d_cnt", n),  bus.count,      tv[n].x_cnt);
      chk($sformatf("v%0d_mask", n), bus.valid_mask, tv[n].x_mask);
      chk($sformatf("v%0d_full", n), bus.full,       tv[n].x_cnt == NR);
    end

    // randomized run: small key alphabet (incl. 0) to force dups and misses
    for (int n = 0; n < 600; n++)
      cyc($urandom_range(0, 1), KW'($urandom_range(0, 5)),
          $urandom_range(0, 2) == 0, IW'($urandom_range(0, 7)),
          $urandom_range(0, 1), KW'($urandom_range(0, 6)));

    // reset lands while a lookup is being sampled: no response may follow
    cyc(1, 'h5A, 0, 0, 0, 0);
    @(negedge clk);
    bus.ins_valid = 0; bus.del_valid = 0;
    bus.look_valid = 1; bus.look_key = 'h5A;
    rst = 1'b1;
    #1 chk_reset_vals("rst_async");
    @(posedge clk); #1;
    chk_reset_vals("rst_mid");
    @(negedge clk);
    rst = 1'b0; bus.look_valid = 0;
    model_reset();
    @(posedge clk); #1;
    compare_all();
    chk("rst_after_empty", bus.empty, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/key_table.md
# key_table

Registered key table that owns the NR-entry key set consumed by the downstream index-lookup mux. Supports insert with automatic lowest-free-slot allocation and duplicate detection, delete by 1-based index, and a registered lookup that returns a 1-based match index, with 0 meaning miss. The flattened key bus and valid mask drive the downstream mux directly; the local lookup port serves sequential clients that need a registered hit.

## Interface
- NR, 4: number of entries (≥1)
- KW, 8: key width
- IW, 3: index width; 2^IW > NR required (0 reserved for miss/none)

- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- ins_valid  in  1  insert request
- ins_ready  out  1  = !full; depends on state only, never on same-cycle inputs
- ins_key  in  KW  key to insert
- ins_done  out  1  registered insert response pulse
- ins_idx  out  IW  1-based slot of inserted or existing key
- ins_dup  out  1  key already present, no allocation
- del_valid  in  1  delete request
- del_idx  in  IW  1-based slot to free
- look_valid  in  1  lookup request
- look_key  in  KW  key to look up
- hit_valid  out  1  registered lookup response pulse
- hit_idx  out  IW  1-based lowest matching valid slot, 0 on miss
- keys  out  NR*KW  slot i at [KW*i+KW-1:KW*i], registered
- valid_mask  out  NR  bit i = slot i occupied
- count  out  IW  occupied slots
- full  out  1  count == NR
- empty  out  1  count == 0

## Operation
- Insert fires on ins_valid && ins_ready.
  - Match search uses pre-cycle valid entries.
  - On match: no state change; the response reports ins_dup=1 and ins_idx=matching slot+1.
  - On miss: the lowest-index free slot (pre-cycle) is written with ins_key and set valid. The response reports ins_dup=0 and ins_idx=slot+1.
- Insert while !ins_ready is ignored: no response, no state change.
- Delete fires on del_valid.
  - If 1 ≤ del_idx ≤ NR and the slot is valid: clear the valid bit and zero the stored key.
  - Otherwise (0, >NR, or already-free slot): ignored, no error output.
- Lookup fires on look_valid. It compares look_key against pre-cycle valid entries only. The lowest matching index wins.
- Invalid slots never match, even if look_key is 0.
- Simultaneous events in one cycle:
  - Lookup, insert and delete all see pre-cycle state.
  - A slot freed this cycle is not reused by a same-cycle insert.
  - Delete of slot k plus a duplicate-insert that matched slot k: the delete applies, and the response still reports ins_dup=1, ins_idx=k.
  - When full, a same-cycle delete does not raise ins_ready this cycle; ins_ready rises next cycle.
- count next = count + (allocating insert) − (effective delete). Wraps impossible by construction.
- full and empty are derived combinationally from registered count.

## Timing
- Reset values:
  - All valid bits 0, all keys 0, count 0.
  - empty 1, full 0, ins_ready 1.
  - ins_done 0, ins_idx 0, ins_dup 0.
  - hit_valid 0, hit_idx 0.
- Reset mid-operation: state clears immediately and asynchronously; pending responses are dropped (no ins_done/hit_valid after reset).
- Insert: request in cycle N → ins_done=1 in cycle N+1 with ins_idx/ins_dup. keys/valid_mask/count updated in N+1. ins_done is high for exactly one cycle per accepted insert.
- ins_idx/ins_dup hold their last value when ins_done=0.
- Delete: visible on keys/valid_mask/count in N+1.
- Lookup: look_valid in N → hit_valid=1 with hit_idx in N+1.
  - Back-to-back lookups are supported every cycle, with throughput 1/cycle.
  - hit_idx holds when hit_valid=0.
- No combinational path from any input to any output except none; all outputs are registered or derived from registers.

## Test plan
- Reset, then insert keys 0x11, 0x22, 0x33 on consecutive cycles → ins_done on each following cycle with ins_idx 1, 2, 3. After the third response, count=3 and valid_mask=0b0111.
- Insert 0x22 again → ins_done with ins_dup=1, ins_idx=2; count stays 3.
- Fill NR=4 with a fourth insert → full=1, ins_ready=0.
  - A fifth insert while full is ignored (no ins_done).
  - Delete idx 2 in the same cycle as another insert → insert ignored; slot 2 freed next cycle; ins_ready=1 next cycle.
  - The next insert of 0x44 gets ins_idx=2.
- Lookup sequencing with 0x33 in slot 3:
  - Lookup 0x33 → hit_idx=3 one cycle later.
  - Lookup 0x99 → hit_idx=0.
  - Lookup 0x00 on an empty table → hit_idx=0.
  - Lookup 0x33 in the same cycle as delete idx 3 → hit_idx=3; the repeat lookup next cycle → hit_idx=0.
- Delete with del_idx 0, 5 (>NR), and an already-free slot → no change to valid_mask/count.
- Assert rst for one cycle between a lookup request and its response → hit_valid stays 0, all outputs return to reset values, and empty=1.
